rom_boot_loader: RTL

- Boot-time copy engine placed directly downstream of the generated boot ROM.
- Walks the ROM byte address from 0 until the ROM flags its last byte, and packs the bytes little-endian into 32-bit words.
- Writes each word into main memory through a ready-handshaked write port.
- Holds the CPU in reset until the image is fully loaded, then releases it.

---
 rtl/rom_boot_loader_if.sv | 22 ++
 rtl/rom_boot_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/rom_boot_loader_if.sv
// Main-memory write port of the boot loader: one word write per request,
// held by the loader until the memory raises mem_ready.
interface rom_boot_loader_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_ready;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write_enable,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write_enable,
    output mem_ready
  );
endinterface

// File: rtl/rom_boot_loader.sv
// Boot copy engine: streams the combinational boot ROM byte by byte, packs the
// bytes little-endian into words, writes them to main memory, then frees the CPU.
module rom_boot_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'd0,
  parameter int unsigned MAX_BYTES    = 65536
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic [31:0]              rom_address,
  input  logic [7:0]               rom_byte,
  input  logic                     rom_done,
  rom_boot_loader_if.master        mem,
  output logic                     boot_done,
  output logic                     cpu_reset_n,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [31:0] LIMIT_ADDRESS = 32'(MAX_BYTES - 1);

  state_t          state, state_next;
  logic [3:0][7:0] buffer;
  logic [3:0][7:0] word_full;
  logic            last_q;
  logic [1:0]      lane;
  logic            at_limit;
  logic            read_last;
  logic            word_ready;
  logic            accept;

  always_ff @(posedge clock or negedge reset_n) begin : state_reg
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: a default for every output at the top of a combinational block keeps
  // any path through the case from holding an old value, so no latch is inferred.
  always_comb begin : next_state
    state_next = state;
    case (state)
      IDLE:    state_next = READ;
      READ:    if (word_ready) state_next = WRITE;
      WRITE:   if (accept)     state_next = last_q ? DONE : READ;
      default: state_next = DONE;
    endcase
  end

  always_comb begin : decode
    lane            = rom_address[1:0];
    at_limit        = (rom_address == LIMIT_ADDRESS);
    read_last       = rom_done || at_limit;
    word_full       = buffer;
    word_full[lane] = rom_byte;
    word_ready      = (state == READ) && ((lane == 2'd3) || read_last);
    accept          = (state == WRITE) && mem.mem_write_enable && mem.mem_ready;
  end

  // NOTE: all registered state, including the word buffer, is cleared by the
  // async reset so a load restarted mid-image never leaks stale bytes; sequential
  // state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin : datapath
    if (!reset_n) begin
      rom_address          <= '0;
      buffer               <= '0;
      last_q               <= 1'b0;
      mem.mem_address      <= '0;
      mem.mem_write_data   <= '0;
      mem.mem_write_enable <= 1'b0;
      boot_done            <= 1'b0;
      cpu_reset_n          <= 1'b0;
      overflow             <= 1'b0;
    end else begin
      case (state)
        READ: begin
          buffer <= word_full;
          // rom_done on the limit byte is a legal end of image, not an overflow.
          if (at_limit && !rom_done) overflow <= 1'b1;
          if (word_ready) begin
            mem.mem_address      <= BASE_ADDRESS + {rom_address[31:2], 2'b00};
            mem.mem_write_data   <= word_full;
            mem.mem_write_enable <= 1'b1;
            last_q               <= read_last;
          end else begin
            rom_address <= rom_address + 32'd1;
          end
        end
        WRITE: begin
          if (accept) begin
            mem.mem_write_enable <= 1'b0;
            buffer               <= '0;
            if (last_q) begin
              boot_done   <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              rom_address <= rom_address + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
